multicycle_main_fsm: RTL and testbench
======================================

Name: multicycle_main_fsm

Overview:
- Moore-style main control FSM for the multi-cycle RV32I core.
- Sequences one shared ALU, memory port, instruction register and register-file write port through fetch/decode/execute/writeback steps.
- Drives every datapath enable and the select lines of the PC/address, ALU-source and result muxes.
- Adds a memory-ready stall handshake and a sticky illegal-opcode trap.

Parameters:
- RESET_STATE, 4'd0 (FETCH): state entered on reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- op  input  7  instruction opcode field, taken from the instruction register.
- Zero  input  1  ALU zero flag.
- mem_ready  input  1  memory has completed the current access this cycle.
- PCWrite  output  1  PC register enable.
- AdrSrc  output  1  memory address select: 0=PC, 1=ALUOut.
- MemWrite  output  1  data memory write strobe.
- IRWrite  output  1  instruction register enable; OldPC latches with it.
- ResultSrc  output  2  result mux select: 00=ALUOut, 01=Data, 10=ALUResult, 11=ImmExt.
- ALUSrcA  output  2  ALU source A select: 00=PC, 01=OldPC, 10=RD1.
- ALUSrcB  output  2  ALU source B select: 00=RD2, 01=ImmExt, 10=constant 4.
- ALUOp  output  2  ALU operation class: 00=add, 01=subtract, 10=decode from funct fields.
- RegWrite  output  1  register file write enable.
- halt  output  1  sticky trap indicator.
- retire  output  1  one-cycle pulse on the last cycle of each instruction.
- state_dbg  output  4  current state encoding.

Behaviour:
- State register: 4 bits. Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10, LUI=11, TRAP=12. Codes 13–15 go to TRAP.
- Reset: on a rising edge with reset=1, state <= FETCH. While reset=1, PCWrite, IRWrite, MemWrite, RegWrite and retire are forced to 0. halt=0 after reset.
- Default outputs in every state: all enables 0, all selects 00, unless listed below.
- PCWrite = PCUpdate | (Branch & Zero). PCUpdate and Branch are internal signals.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=PCUpdate=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE otherwise.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - 0110111 -> LUI
  - any other value -> TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD if op=0000011, else MEMWRITE. Op is sampled again here and is held stable by the IR.
- MEMREAD: AdrSrc=1, ResultSrc=00. Waits for mem_ready=1, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, retire=1. Goes to FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. MemWrite stays high every cycle until mem_ready=1. retire=1 in the cycle where mem_ready=1, then goes to FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Goes to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, retire=1. Goes to FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, retire=1. Goes to FETCH. The PC loads ALUOut only if Zero=1 in this cycle.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Goes to ALUWB, which writes OldPC+4 to rd.
- LUI: ResultSrc=11, RegWrite=1, retire=1. Goes to FETCH.
- TRAP: halt=1 and all enables 0. Absorbing; only reset exits.
- Latency in cycles, with mem_ready tied high:
  - lw 5
  - sw 4
  - R-type and I-type ALU 4
  - beq 3
  - jal 4
  - lui 3
- Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- reset asserted during any state, including a stalled access or TRAP, returns to FETCH on the next edge. No partial write is issued in the reset cycle.
- Zero and mem_ready affect outputs only in the states named above.

Test Plan:
- Reset, then op=0110011 with mem_ready=1 -> states FETCH, DECODE, EXECUTER, ALUWB, FETCH. RegWrite=1 only in ALUWB, with ResultSrc=00. retire pulses once.
- op=0000011, mem_ready low for 2 cycles in MEMREAD -> MEMREAD lasts 3 cycles with AdrSrc=1 and RegWrite=0. MEMWB then has ResultSrc=01 and RegWrite=1. Total 7 cycles.
- op=0100011, mem_ready low for 1 cycle -> MemWrite=1 for 2 consecutive cycles, then FETCH. RegWrite is never asserted.
- op=1100011 with Zero=1, then again with Zero=0 -> in the BEQ cycle, PCWrite=1 in the first case and 0 in the second. Both take 3 cycles.
- op=0110111 -> LUI cycle has ResultSrc=11 and RegWrite=1. op=1101111 -> PCWrite=1 in JAL, then RegWrite=1 with ResultSrc=00 in ALUWB.
- op=1111111 -> TRAP. halt stays 1 for 10+ cycles with all enables 0. Asserting reset for 1 cycle -> state_dbg=0, halt=0.

Source files
------------

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch/decode/execute/writeback
// over a shared ALU and memory port, with a memory-ready stall and a sticky illegal-op trap.
module multicycle_main_fsm #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegWrite,
  output logic       halt,
  output logic       retire,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  state_t state_q, state_d;
  logic   pc_update, branch, mem_write, ir_write, reg_write, retire_raw;

  always_ff @(posedge clk) begin
    if (reset) state_q <= state_t'(RESET_STATE);
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_update  = 1'b0;
    branch     = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    retire_raw = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    halt       = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_write  = mem_ready;
        pc_update = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BEQ:            state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        reg_write  = 1'b1;
        retire_raw = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        // strobe held for the whole access; the instruction retires on the ready cycle
        AdrSrc     = 1'b1;
        mem_write  = 1'b1;
        retire_raw = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        retire_raw = 1'b1;
        state_d    = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b01;
        branch     = 1'b1;
        retire_raw = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        // ALU forms OldPC+4 for the link write in ALUWB
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_LUI: begin
        ResultSrc  = 2'b11;
        reg_write  = 1'b1;
        retire_raw = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP: begin
        halt    = 1'b1;
        state_d = S_TRAP;
      end
      default: state_d = S_TRAP;
    endcase
  end

  assign PCWrite   = ~reset & (pc_update | (branch & Zero));
  assign IRWrite   = ~reset & ir_write;
  assign MemWrite  = ~reset & mem_write;
  assign RegWrite  = ~reset & reg_write;
  assign retire    = ~reset & retire_raw;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Randomized scoreboard bench for multicycle_main_fsm: per-cycle output vectors and
// per-instruction retire latency are predicted from instruction-level phase lists.
module tb_multicycle_main_fsm;

  logic       clk = 1'b0;
  logic       reset, Zero, mem_ready;
  logic [6:0] op;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, halt, retire;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [3:0] state_dbg;

  multicycle_main_fsm dut (
    .clk(clk), .reset(reset), .op(op), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .RegWrite(RegWrite), .halt(halt), .retire(retire), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, mw, irw;
    logic [1:0] rs, sa, sb, aop;
    logic       rw, hlt, ret;
  } obs_t;

  typedef struct {
    obs_t o;
    bit   rst;
  } item_t;

  item_t eq[$];
  int    iq[$];
  int    total = 0;
  int    bad   = 0;
  int    ncyc  = 0;

  // Expected outputs for one cycle spent in phase s, given the inputs of that cycle.
  function automatic obs_t expect_obs(int s, bit mr, bit z, bit rst);
    obs_t o;
    o    = '0;
    o.st = 4'(s);
    case (s)
      0:  begin o.sb = 2'b10; o.rs = 2'b10; o.irw = mr; o.pcw = mr; end
      1:  begin o.sa = 2'b01; o.sb = 2'b01; end
      2:  begin o.sa = 2'b10; o.sb = 2'b01; end
      3:  begin o.adr = 1'b1; end
      4:  begin o.rs = 2'b01; o.rw = 1'b1; o.ret = 1'b1; end
      5:  begin o.adr = 1'b1; o.mw = 1'b1; o.ret = mr; end
      6:  begin o.sa = 2'b10; o.aop = 2'b10; end
      7:  begin o.sa = 2'b10; o.sb = 2'b01; o.aop = 2'b10; end
      8:  begin o.rw = 1'b1; o.ret = 1'b1; end
      9:  begin o.sa = 2'b10; o.aop = 2'b01; o.ret = 1'b1; o.pcw = z; end
      10: begin o.sa = 2'b01; o.sb = 2'b10; o.pcw = 1'b1; end
      11: begin o.rs = 2'b11; o.rw = 1'b1; o.ret = 1'b1; end
      12: begin o.hlt = 1'b1; end
      default: ;
    endcase
    if (rst) begin
      o.pcw = 1'b0; o.irw = 1'b0; o.mw = 1'b0; o.rw = 1'b0; o.ret = 1'b0;
    end
    return o;
  endfunction

  task automatic cyc(int s, bit mr, bit z, bit rst, logic [6:0] o);
    item_t it;
    reset     = rst;
    mem_ready = mr;
    Zero      = z;
    op        = o;
    it.o      = expect_obs(s, mr, z, rst);
    it.rst    = rst;
    eq.push_back(it);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(logic [6:0] o, int fst, int mst, bit z);
    int seq[$];
    int lat = 0;
    bit legal = 1'b1;
    bit is_mem = 1'b0;
    case (o)
      7'b0000011: begin seq = '{0, 1, 2, 3, 4}; lat = 5; is_mem = 1'b1; end
      7'b0100011: begin seq = '{0, 1, 2, 5};    lat = 4; is_mem = 1'b1; end
      7'b0110011: begin seq = '{0, 1, 6, 8};    lat = 4; end
      7'b0010011: begin seq = '{0, 1, 7, 8};    lat = 4; end
      7'b1100011: begin seq = '{0, 1, 9};       lat = 3; end
      7'b1101111: begin seq = '{0, 1, 10, 8};   lat = 4; end
      7'b0110111: begin seq = '{0, 1, 11};      lat = 3; end
      default:    begin seq = '{0, 1};          legal = 1'b0; end
    endcase
    if (legal) iq.push_back(lat + fst + (is_mem ? mst : 0));
    foreach (seq[i]) begin
      if (seq[i] == 0) begin
        repeat (fst) cyc(0, 1'b0, 1'($urandom), 1'b0, 7'($urandom));
        cyc(0, 1'b1, 1'($urandom), 1'b0, 7'($urandom));
      end else if (seq[i] == 3 || seq[i] == 5) begin
        repeat (mst) cyc(seq[i], 1'b0, 1'($urandom), 1'b0, o);
        cyc(seq[i], 1'b1, 1'($urandom), 1'b0, o);
      end else if (seq[i] == 9) begin
        cyc(9, 1'($urandom), z, 1'b0, o);
      end else begin
        cyc(seq[i], 1'($urandom), 1'($urandom), 1'b0, o);
      end
    end
    if (!legal) begin
      repeat (12) cyc(12, 1'($urandom), 1'($urandom), 1'b0, o);
      cyc(12, 1'($urandom), 1'($urandom), 1'b1, o);
    end
  endtask

  // Store aborted by reset while its memory access is still stalled.
  task automatic run_abort_sw();
    logic [6:0] sw = 7'b0100011;
    cyc(0, 1'b1, 1'b0, 1'b0, sw);
    cyc(1, 1'b0, 1'b0, 1'b0, sw);
    cyc(2, 1'b0, 1'b0, 1'b0, sw);
    cyc(5, 1'b0, 1'b0, 1'b0, sw);
    cyc(5, 1'b0, 1'b0, 1'b1, sw);
  endtask

  initial begin : monitor
    item_t it;
    obs_t  act;
    int    lat;
    forever begin
      @(negedge clk);
      if (eq.size() > 0) begin
        it  = eq.pop_front();
        act = {state_dbg, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUOp, RegWrite, halt, retire};
        total++;
        if (act !== it.o) begin
          bad++;
          $display("FAIL outputs t=%0t got=%h exp=%h (st/pcw/adr/mw/irw/rs/sa/sb/aop/rw/halt/ret)",
                   $time, act, it.o);
        end
        if (it.rst) begin
          ncyc = 0;
        end else begin
          ncyc++;
          if (retire === 1'b1) begin
            total++;
            if (iq.size() == 0) begin
              bad++;
              $display("FAIL latency t=%0t got=%0d exp=no retire", $time, ncyc);
            end else begin
              lat = iq.pop_front();
              if (ncyc != lat) begin
                bad++;
                $display("FAIL latency t=%0t got=%0d exp=%0d", $time, ncyc, lat);
              end
            end
            ncyc = 0;
          end
        end
      end
    end
  end

  initial begin : stimulus
    logic [6:0] legal_ops [7];
    legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                  7'b1100011, 7'b1101111, 7'b0110111};
    reset = 1'b1; mem_ready = 1'b0; Zero = 1'b0; op = '0;
    repeat (2) @(posedge clk);
    #1;
    cyc(0, 1'b1, 1'b0, 1'b1, 7'b0110011);

    run_instr(7'b0110011, 0, 0, 1'b0);
    run_instr(7'b0000011, 0, 2, 1'b0);
    run_instr(7'b0100011, 0, 1, 1'b0);
    run_instr(7'b1100011, 0, 0, 1'b1);
    run_instr(7'b1100011, 0, 0, 1'b0);
    run_instr(7'b0110111, 0, 0, 1'b0);
    run_instr(7'b1101111, 0, 0, 1'b0);
    run_instr(7'b0010011, 2, 0, 1'b0);
    run_abort_sw();
    run_instr(7'b0000011, 1, 1, 1'b0);
    for (int i = 0; i < 60; i++)
      run_instr(legal_ops[$urandom_range(6)], $urandom_range(2), $urandom_range(3),
                1'($urandom));
    run_instr(7'b1111111, 0, 0, 1'b0);
    run_instr(7'b0110011, 0, 0, 1'b0);
    run_instr(7'b0000000, 1, 0, 1'b0);
    run_instr(7'b1100011, 0, 0, 1'b1);

    for (int k = 0; k < 10 && eq.size() > 0; k++) @(negedge clk);
    @(posedge clk);
    total++;
    if (eq.size() != 0 || iq.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d/%0d pending exp=0/0", eq.size(), iq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
